sseg_scan: RTL and testbench

Parametrised multiplexed seven-segment display scanner for the FPGA board build: it drives DIGITS common-anode digits from a hex value bus. It adds four things to the fixed 4-digit insn display: tear-free frame-synchronous loading, per-digit blanking and decimal points, leading-zero suppression, and 16-level brightness PWM with anti-ghosting dead time. It sits between the CPU debug/status registers and the board anode/cathode pins.

---
 rtl/sseg_scan.sv | 153 +++++++++++++++
 tb/tb_sseg_scan.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous loading,
// leading-zero suppression, per-digit blank/dp and 16-level PWM with dead time.
module sseg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16384,
  parameter int DEAD     = 64
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  input  logic                  lzs,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            cathode,
  output logic                  dp_n,
  output logic                  frame_start
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
  localparam logic [SW-1:0] DEAD_CNT   = SW'(DEAD);

  logic [SW-1:0]       slot_cnt;
  logic [DW-1:0]       digit_idx;
  logic                slot_wrap;
  logic                frame_wrap;

  logic [4*DIGITS-1:0] pend_value;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   pend_blank;
  logic [4*DIGITS-1:0] disp_value;
  logic [DIGITS-1:0]   disp_dp;
  logic [DIGITS-1:0]   disp_blank;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                cur_supp;
  logic                higher_zero;
  logic                lit;
  logic [DIGITS-1:0]   anode_nxt;

  // Active-high gfedcba patterns, inverted for the common-anode cathodes.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return ~seg;
  endfunction

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (digit_idx == DIGIT_LAST);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (frame_wrap)
        digit_idx <= '0;
      else if (slot_wrap)
        digit_idx <= digit_idx + 1'b1;
    end
  end

  // Blank defaults to all ones so nothing lights before the first load reaches disp.
  // disp copies the pre-edge pending value, so a load on the boundary waits a frame.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '1;
    end else begin
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank;
      end
      if (frame_wrap) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
    end
  end

  // Walk from the most significant digit down so higher_zero covers nibbles k..DIGITS-1.
  always_comb begin
    cur_nib     = '0;
    cur_dp      = 1'b0;
    cur_blank   = 1'b1;
    cur_supp    = 1'b0;
    higher_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero && (disp_value[4*k +: 4] == 4'h0);
      if (DW'(k) == digit_idx) begin
        cur_nib   = disp_value[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = disp_blank[k];
        cur_supp  = lzs && (k != 0) && higher_zero;
      end
    end
  end

  assign lit = (slot_cnt >= DEAD_CNT) && (slot_cnt[3:0] < bright) &&
               !cur_blank && !cur_supp;

  always_comb begin
    anode_nxt = '1;
    for (int k = 0; k < DIGITS; k++)
      anode_nxt[k] = !(lit && (DW'(k) == digit_idx));
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      anode       <= '1;
      cathode     <= '1;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_nxt;
      cathode     <= lit ? glyph(cur_nib) : 7'h7F;
      dp_n        <= lit ? !cur_dp : 1'b1;
      frame_start <= (digit_idx == '0) && (slot_cnt == '0);
    end
  end

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan: frame-position reference model feeds an expected queue,
// a negedge monitor compares every output cycle, plus directed duty/reset checks.
module tb_sseg_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 32;
  localparam int DEAD     = 4;
  localparam int P        = DIGITS * SCAN_DIV;
  localparam logic [12:0] RST_EXP = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic        clk;
  logic        res;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic        lzs;
  logic [3:0]  bright;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp_n;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_q[$];

  // Model state: clocks since release, pending and displayed frame contents.
  int          n;
  logic [15:0] m_pend_v, m_disp_v;
  logic [3:0]  m_pend_dp, m_disp_dp, m_pend_bl, m_disp_bl;

  int lit_cnt = 0;

  logic [6:0] seg_tab [16];

  sseg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD)) dut (
    .clk(clk), .res(res), .value(value), .dp(dp), .blank(blank), .load(load),
    .lzs(lzs), .bright(bright), .anode(anode), .cathode(cathode), .dp_n(dp_n),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    seg_tab[0]  = 7'b0111111; seg_tab[1]  = 7'b0000110;
    seg_tab[2]  = 7'b1011011; seg_tab[3]  = 7'b1001111;
    seg_tab[4]  = 7'b1100110; seg_tab[5]  = 7'b1101101;
    seg_tab[6]  = 7'b1111101; seg_tab[7]  = 7'b0000111;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1101111;
    seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b1111100;
    seg_tab[12] = 7'b0111001; seg_tab[13] = 7'b1011110;
    seg_tab[14] = 7'b1111001; seg_tab[15] = 7'b1110001;
  end

  // Expected outputs after the clock at frame position pos.
  function automatic logic [12:0] model_out(int pos, logic lz, logic [3:0] br);
    int         d   = pos / SCAN_DIV;
    int         off = pos % SCAN_DIV;
    logic [3:0] nib = 4'((m_disp_v >> (4 * d)) & 16'hF);
    logic       supp = lz && (d > 0) && ((m_disp_v >> (4 * d)) == 16'h0);
    logic       on = (off >= DEAD) && ((off % 16) < int'(br)) && !m_disp_bl[d] && !supp;
    logic [3:0] an = on ? ~(4'b0001 << d) : 4'hF;
    logic [6:0] ca = on ? ~seg_tab[nib] : 7'h7F;
    logic       dn = on ? ~m_disp_dp[d] : 1'b1;
    return {an, ca, dn, (pos == 0)};
  endfunction

  function automatic int lit_per_frame(logic [3:0] br);
    int c = 0;
    for (int off = DEAD; off < SCAN_DIV; off++)
      if ((off % 16) < int'(br)) c++;
    return c * DIGITS;
  endfunction

  always @(posedge clk or negedge res) begin
    if (!res) begin
      exp_q.delete();
      exp_q.push_back(RST_EXP);
      n         <= 0;
      m_pend_v  <= '0; m_pend_dp <= '0; m_pend_bl <= '1;
      m_disp_v  <= '0; m_disp_dp <= '0; m_disp_bl <= '1;
    end else begin
      exp_q.push_back(model_out(n % P, lzs, bright));
      if ((n % P) == P - 1) begin
        m_disp_v <= m_pend_v; m_disp_dp <= m_pend_dp; m_disp_bl <= m_pend_bl;
      end
      if (load) begin
        m_pend_v <= value; m_pend_dp <= dp; m_pend_bl <= blank;
      end
      n <= n + 1;
    end
  end

  always @(negedge clk) begin
    logic [12:0] got, exp;
    if (exp_q.size() > 0) begin
      got = {anode, cathode, dp_n, frame_start};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL outputs t=%0t got an=%b ca=%b dpn=%b fs=%b required an=%b ca=%b dpn=%b fs=%b",
                 $time, got[12:9], got[8:2], got[1], got[0], exp[12:9], exp[8:2], exp[1], exp[0]);
      end
    end
    if (anode !== 4'hF) lit_cnt++;
  end

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Park on the negedge before the clock whose pre-edge frame position is target.
  task automatic wait_pos(input int target);
    int guard = 0;
    while ((n % P) != target && guard < 2 * P) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if ((n % P) != target) begin
      errors++;
      $display("FAIL wait_pos got %0d required %0d", n % P, target);
    end
  endtask

  task automatic check_duty(input string name, input int required);
    int start = lit_cnt;
    run(P);
    checks++;
    if (lit_cnt - start != required) begin
      errors++;
      $display("FAIL %s lit cycles got %0d required %0d", name, lit_cnt - start, required);
    end
  endtask

  initial begin
    res = 1'b0; value = '0; dp = '0; blank = '0; load = 1'b0; lzs = 1'b0; bright = 4'd15;
    run(3);
    checks++;
    if ({anode, cathode, dp_n, frame_start} !== RST_EXP) begin
      errors++;
      $display("FAIL reset_state got %b required %b", {anode, cathode, dp_n, frame_start}, RST_EXP);
    end
    res = 1'b1;

    do_load(16'h1234, 4'b0000, 4'b0000);
    run(2 * P);
    check_duty("full_bright", lit_per_frame(4'd15));

    do_load(16'h0007, 4'b0000, 4'b0000);
    lzs = 1'b1;
    run(2 * P);
    check_duty("lzs_on", lit_per_frame(4'd15) / DIGITS);
    lzs = 1'b0;
    run(P);

    wait_pos(2 * SCAN_DIV + 5);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    wait_pos(P - 1);
    do_load(16'h5555, 4'b0000, 4'b0000);
    run(3 * P);

    do_load(16'h1234, 4'b0000, 4'b0000);
    bright = 4'd4;
    run(2 * P);
    check_duty("bright4", lit_per_frame(4'd4));
    bright = 4'd0;
    check_duty("bright0", 0);
    bright = 4'd15;

    do_load(16'h00F0, 4'b0010, 4'b1000);
    run(3 * P);

    wait_pos(2 * SCAN_DIV + 10);
    @(posedge clk);
    #2 res = 1'b0;
    #1;
    checks++;
    if ({anode, cathode, dp_n, frame_start} !== RST_EXP) begin
      errors++;
      $display("FAIL async_reset got %b required %b", {anode, cathode, dp_n, frame_start}, RST_EXP);
    end
    run(3);
    res = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_start got %b required 1", frame_start);
    end
    check_duty("dark_after_reset", 0);

    for (int i = 0; i < 40; i++) begin
      lzs    = 1'($urandom_range(0, 1));
      bright = 4'($urandom_range(0, 15));
      run($urandom_range(0, P));
      do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) < 10 ? 0 : $urandom));
      if ($urandom_range(0, 3) == 0)
        do_load(16'($urandom_range(0, 15)), 4'($urandom), 4'b0000);
      run($urandom_range(P, 2 * P));
    end
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
